// File: rtl/rtc_write_sequencer.sv
// Writes the nine time/date/timer bytes from the register bank into the external RTC
// as address-then-data transactions on its multiplexed parallel bus.
module rtc_write_sequencer #(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_WR  = 6,
  parameter int unsigned T_HD  = 2,
  parameter int unsigned T_GAP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_write,
  input  logic       timer_only,
  input  logic [7:0] in_seg_hora,
  input  logic [7:0] in_min_hora,
  input  logic [7:0] in_hora_hora,
  input  logic [7:0] in_dia_fecha,
  input  logic [7:0] in_mes_fecha,
  input  logic [7:0] in_jahr_fecha,
  input  logic [7:0] in_seg_timer,
  input  logic [7:0] in_min_timer,
  input  logic [7:0] in_hora_timer,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_A_SU, S_A_WR, S_A_HD, S_D_SU, S_D_WR, S_D_HD, S_GAP, S_NEXT, S_DONE
  } state_t;

  localparam logic [3:0] IDX_FIRST_TIMER = 4'd6;
  localparam logic [3:0] IDX_LAST        = 4'd8;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic       load_snap;
  logic [7:0] snap_q [9];

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h21;
      4'd1:    return 8'h22;
      4'd2:    return 8'h23;
      4'd3:    return 8'h24;
      4'd4:    return 8'h25;
      4'd5:    return 8'h26;
      4'd6:    return 8'h41;
      4'd7:    return 8'h42;
      default: return 8'h43;
    endcase
  endfunction

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    idx_d     = idx_q;
    load_snap = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_write) begin
        load_snap = 1'b1;
        idx_d     = timer_only ? IDX_FIRST_TIMER : 4'd0;
        state_d   = S_A_SU;
        cnt_d     = 8'(T_SU - 1);
      end
      S_A_SU: if (cnt_q == 8'd0) begin state_d = S_A_WR; cnt_d = 8'(T_WR - 1);  end
      S_A_WR: if (cnt_q == 8'd0) begin state_d = S_A_HD; cnt_d = 8'(T_HD - 1);  end
      S_A_HD: if (cnt_q == 8'd0) begin state_d = S_D_SU; cnt_d = 8'(T_SU - 1);  end
      S_D_SU: if (cnt_q == 8'd0) begin state_d = S_D_WR; cnt_d = 8'(T_WR - 1);  end
      S_D_WR: if (cnt_q == 8'd0) begin state_d = S_D_HD; cnt_d = 8'(T_HD - 1);  end
      S_D_HD: if (cnt_q == 8'd0) begin state_d = S_GAP;  cnt_d = 8'(T_GAP - 1); end
      S_GAP:  if (cnt_q == 8'd0) state_d = S_NEXT;
      S_NEXT: if (idx_q == IDX_LAST) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_A_SU;
        cnt_d   = 8'(T_SU - 1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state and registered, so pins change only on clk.
  logic       addr_ph, data_ph;
  logic [7:0] ad_out_d;
  always_comb begin
    addr_ph  = (state_d == S_A_SU) || (state_d == S_A_WR) || (state_d == S_A_HD);
    data_ph  = (state_d == S_D_SU) || (state_d == S_D_WR) || (state_d == S_D_HD);
    ad_out_d = 8'h00;
    if (addr_ph)      ad_out_d = reg_addr(idx_d);
    else if (data_ph) ad_out_d = snap_q[idx_d];
  end

  // NOTE: the snapshot is plain storage, never read before it is loaded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_snap) begin
      snap_q[0] <= in_seg_hora;
      snap_q[1] <= in_min_hora;
      snap_q[2] <= in_hora_hora;
      snap_q[3] <= in_dia_fecha;
      snap_q[4] <= in_mes_fecha;
      snap_q[5] <= in_jahr_fecha;
      snap_q[6] <= in_seg_timer;
      snap_q[7] <= in_min_timer;
      snap_q[8] <= in_hora_timer;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 4'd0;
      cs_n    <= 1'b1;
      wr_n    <= 1'b1;
      a_d     <= 1'b0;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cs_n    <= !(addr_ph || data_ph);
      wr_n    <= !((state_d == S_A_WR) || (state_d == S_D_WR));
      a_d     <= data_ph;
      ad_oe   <= addr_ph || data_ph;
      ad_out  <= ad_out_d;
      busy    <= (state_d != S_IDLE) && (state_d != S_DONE);
      done    <= (state_d == S_DONE);
    end
  end

  // This sequencer never reads the RTC.
  assign rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Randomized self-checking bench: a bus monitor decodes RTC write transactions and
// compares them with an expected (address, data) list built from the register order.
module tb_rtc_write_sequencer;

  localparam int T_SU = 2, T_WR = 6, T_HD = 2, T_GAP = 4;
  localparam int TXN_CYCLES = 2 * (T_SU + T_WR + T_HD) + T_GAP + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_write = 1'b0;
  logic       timer_only = 1'b0;
  logic [7:0] vals [9];
  logic [7:0] ad_out;
  logic       ad_oe, a_d, cs_n, wr_n, rd_n, busy, done;

  always #5 clk = ~clk;

  rtc_write_sequencer dut (
    .clk(clk), .reset(reset), .start_write(start_write), .timer_only(timer_only),
    .in_seg_hora(vals[0]), .in_min_hora(vals[1]), .in_hora_hora(vals[2]),
    .in_dia_fecha(vals[3]), .in_mes_fecha(vals[4]), .in_jahr_fecha(vals[5]),
    .in_seg_timer(vals[6]), .in_min_timer(vals[7]), .in_hora_timer(vals[8]),
    .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs_n(cs_n), .wr_n(wr_n),
    .rd_n(rd_n), .busy(busy), .done(done)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: RTC address of each bank register, in write order.
  logic [7:0]  addr_tab [9];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];

  // Monitor state
  int         busy_cnt, done_cnt, viol, pulse_bad, plen;
  logic       in_pulse, pa_d, prev_reset, prev_wr_n, prev_cs_n, prev_a_d;
  logic [7:0] pbyte, cur_addr, prev_ad;

  initial begin
    in_pulse = 0; prev_reset = 1; busy_cnt = 0; done_cnt = 0; viol = 0; pulse_bad = 0;
  end

  always @(negedge clk) begin
    if (rd_n !== 1'b1) viol++;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (reset || prev_reset) begin
      in_pulse = 0;
    end else begin
      if (!prev_wr_n && !wr_n && (ad_out != prev_ad || a_d != prev_a_d)) viol++;
      if (wr_n != prev_wr_n && cs_n != prev_cs_n) viol++;
      if (cs_n == ad_oe) viol++;
      if (!wr_n && cs_n) viol++;
      if (!wr_n) begin
        if (!in_pulse) begin
          in_pulse = 1; plen = 1; pa_d = a_d; pbyte = ad_out;
        end else plen++;
      end else if (in_pulse) begin
        in_pulse = 0;
        if (plen != T_WR) pulse_bad++;
        if (!pa_d) cur_addr = pbyte;
        else obs_q.push_back({cur_addr, pbyte});
      end
    end
    prev_reset = reset; prev_wr_n = wr_n; prev_cs_n = cs_n;
    prev_a_d = a_d; prev_ad = ad_out;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_burst(input logic to);
    exp_q.delete();
    for (int i = (to ? 6 : 0); i < 9; i++) exp_q.push_back({addr_tab[i], vals[i]});
    obs_q.delete();
    busy_cnt = 0; done_cnt = 0; viol = 0; pulse_bad = 0;
    timer_only = to; start_write = 1'b1;
    tick();
    start_write = 1'b0; timer_only = 1'($urandom);
  endtask

  task automatic finish_burst(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check({tag, "_done_timeout"}, 1, 0);
    repeat (4) @(negedge clk);
    check({tag, "_ntxn"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", tag, i), (i < obs_q.size()) ? {16'h0, obs_q[i]} : 32'hdead, {16'h0, exp_q[i]});
    check({tag, "_busy_cycles"}, busy_cnt, exp_q.size() * TXN_CYCLES);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_wr_pulse_len"}, pulse_bad, 0);
    check({tag, "_protocol"}, viol, 0);
  endtask

  task automatic load_fixed();
    vals[0] = 8'h45; vals[1] = 8'h30; vals[2] = 8'h12; vals[3] = 8'h07; vals[4] = 8'h04;
    vals[5] = 8'h17; vals[6] = 8'h10; vals[7] = 8'h05; vals[8] = 8'h01;
  endtask

  initial begin
    int n;
    addr_tab[0] = 8'h21; addr_tab[1] = 8'h22; addr_tab[2] = 8'h23;
    addr_tab[3] = 8'h24; addr_tab[4] = 8'h25; addr_tab[5] = 8'h26;
    addr_tab[6] = 8'h41; addr_tab[7] = 8'h42; addr_tab[8] = 8'h43;
    load_fixed();

    // Reset, then idle: bus released every cycle.
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_pins", {26'h0, cs_n, wr_n, rd_n, ad_oe, busy, done}, 32'b111000);
    end
    check("idle_ad_out", ad_out, 8'h00);
    tick();

    start_burst(1'b0); finish_burst("full");
    tick();
    start_burst(1'b1); finish_burst("timer");
    tick();

    // Inputs and a second start mid-burst must not disturb the snapshot.
    start_burst(1'b0);
    n = 0;
    while (obs_q.size() < 2 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("mid_wait_timeout", 1, 0);
    tick();
    for (int i = 0; i < 9; i++) vals[i] = 8'h99;
    start_write = 1'b1; tick(); start_write = 1'b0;
    finish_burst("mid");
    tick();

    // Abort during the data strobe of transaction 4.
    load_fixed();
    start_burst(1'b0);
    n = 0;
    while (!(obs_q.size() == 3 && wr_n == 1'b0 && a_d == 1'b1) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("abort_wait_timeout", 1, 0);
    tick();
    reset = 1'b1;
    tick();
    check("abort_pins", {28'h0, cs_n, wr_n, ad_oe, busy}, 32'b1100);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_busy_low", busy_cnt, 0);
    tick();
    start_burst(1'b0); finish_burst("restart");
    tick();

    // Randomized bursts.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) vals[i] = 8'($urandom);
      start_burst(1'($urandom));
      for (int i = 0; i < 9; i++) vals[i] = 8'($urandom);
      finish_burst($sformatf("rand%0d", r));
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
